// File: rtl/snake_dir_ctrl.sv
// Snake heading/game-state sequencer: edge-detected turn commands, turn filter, one turn applied per tick.
// Optional SNAKE_DIR_QUEUE_EN selects a QDEPTH-entry turn FIFO; otherwise a single overwriteable pending turn.
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       user_start,
  input  logic       cmd_reset,
  input  logic       tick,
  input  logic       collision,
  output logic [1:0] dir,
  output logic       step,
  output logic [1:0] game_state,
  output logic [3:0] q_level,
  output logic       dropped
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, OVER = 2'd2} state_t;

  if (QDEPTH < 1 || QDEPTH > 8) begin : g_bad_qdepth
    $error("snake_dir_ctrl: QDEPTH must be 1..8");
  end

  state_t state, state_nxt;
  logic up_q, down_q, left_q, right_q, start_q, creset_q;
  logic up_ev, down_ev, left_ev, right_ev, start_ev, creset_ev;
  logic       dir_ev;
  logic [1:0] dir_new;
  logic [1:0] ref_dir;
  logic       filt_ok, load_init, do_tick, try_push, push, pop, drop;

  assign up_ev     = up & ~up_q;
  assign down_ev   = down & ~down_q;
  assign left_ev   = left & ~left_q;
  assign right_ev  = right & ~right_q;
  assign start_ev  = user_start & ~start_q;
  assign creset_ev = cmd_reset & ~creset_q;

  always_comb begin
    dir_ev  = up_ev | right_ev | down_ev | left_ev;
    dir_new = 2'd3;
    if (up_ev)         dir_new = 2'd0;
    else if (right_ev) dir_new = 2'd1;
    else if (down_ev)  dir_new = 2'd2;
  end

  always_comb begin
    state_nxt = state;
    if (creset_ev) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ev)  state_nxt = PLAYING;
        PLAYING: if (collision) state_nxt = OVER;
        OVER:    if (start_ev)  state_nxt = PLAYING;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  // Entering IDLE or (re)entering PLAYING restores the heading and empties the turn buffer.
  assign load_init = creset_ev | ((state != PLAYING) & start_ev);
  assign do_tick   = (state == PLAYING) & ~creset_ev & ~collision & tick;
  assign try_push  = (state == PLAYING) & ~creset_ev & dir_ev;
  assign filt_ok   = (dir_new != ref_dir) & (dir_new != (ref_dir ^ 2'd2));

`ifdef SNAKE_DIR_QUEUE_EN
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

  logic [1:0]    q_mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, tail_ptr;
  logic [3:0]    q_cnt;

  assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign ref_dir  = (q_cnt != 4'd0) ? q_mem[tail_ptr] : dir;
  assign push     = try_push & filt_ok & (q_cnt != 4'(QDEPTH));
  assign drop     = try_push & ~push;
  assign pop      = do_tick & (q_cnt != 4'd0);
  assign q_level  = q_cnt;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= dir_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir    <= INIT_DIR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= 4'd0;
    end else if (load_init) begin
      dir    <= INIT_DIR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= 4'd0;
    end else begin
      if (pop) begin
        dir    <= q_mem[rd_ptr];
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      q_cnt <= q_cnt + 4'(push) - 4'(pop);
    end
  end
`else
  logic       pend_vld;
  logic [1:0] pend_dir;

  assign ref_dir = pend_vld ? pend_dir : dir;
  assign push    = try_push & filt_ok;
  assign drop    = try_push & ~filt_ok;
  assign pop     = do_tick & pend_vld;
  assign q_level = {3'b000, pend_vld};

  always_ff @(posedge clk) begin
    if (reset) begin
      dir      <= INIT_DIR;
      pend_vld <= 1'b0;
      pend_dir <= 2'd0;
    end else if (load_init) begin
      dir      <= INIT_DIR;
      pend_vld <= 1'b0;
    end else begin
      if (pop) begin
        dir      <= pend_dir;
        pend_vld <= 1'b0;
      end
      // A newer accepted turn replaces whatever is pending (push wins over a same-cycle pop).
      if (push) begin
        pend_vld <= 1'b1;
        pend_dir <= dir_new;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 1'b0;
      dropped  <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      start_q  <= 1'b0;
      creset_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= do_tick;
      dropped  <= drop;
      up_q     <= up;
      down_q   <= down;
      left_q   <= left;
      right_q  <= right;
      start_q  <= user_start;
      creset_q <= cmd_reset;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl; expected headings are queued per tick and matched against step pulses.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       reset, up, down, left, right, user_start, cmd_reset, tick, collision;
  logic [1:0] dir;
  logic       step;
  logic [1:0] game_state;
  logic [3:0] q_level;
  logic       dropped;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  int drop_cnt = 0;
  int d0, s0;
  logic [1:0] exp_q[$];

  localparam logic [7:0] K_UP = 8'h80, K_DN = 8'h40, K_LT = 8'h20, K_RT = 8'h10;
  localparam logic [7:0] K_ST = 8'h08, K_CR = 8'h04, K_TK = 8'h02, K_CO = 8'h01;

  snake_dir_ctrl #(.QDEPTH(2), .INIT_DIR(2'd1)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .user_start(user_start), .cmd_reset(cmd_reset), .tick(tick), .collision(collision),
    .dir(dir), .step(step), .game_state(game_state), .q_level(q_level), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every step pulse must match the oldest queued heading.
  always @(negedge clk) begin
    if (!reset && step) begin
      step_cnt++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_step observed_dir=%0d expected=no_step", dir);
      end
      if (exp_q.size() != 0) chk("step_dir", dir, exp_q.pop_front());
    end
    if (!reset && dropped) drop_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v);
    {up, down, left, right, user_start, cmd_reset, tick, collision} = v;
    cyc(1);
    {up, down, left, right, user_start, cmd_reset, tick, collision} = 8'h00;
    cyc(1);
  endtask

  task automatic tick_exp(input logic [1:0] d);
    exp_q.push_back(d);
    drive(K_TK);
    chk("step_seen", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {up, down, left, right, user_start, cmd_reset, tick, collision} = 8'h00;
    cyc(3);
    chk("rst_state", game_state, 0);
    chk("rst_dir", dir, 1);
    chk("rst_qlevel", q_level, 0);
    chk("rst_step", step, 0);
    chk("rst_dropped", dropped, 0);
    reset = 1'b0;
    cyc(2);

    drive(K_ST);
    chk("start_playing", game_state, 1);
    tick_exp(2'd1);
    tick_exp(2'd1);
    tick_exp(2'd1);
    chk("three_steps", step_cnt, 3);

    // Held reversal key: exactly one rejection.
    d0 = drop_cnt;
    left = 1'b1;
    cyc(20);
    left = 1'b0;
    cyc(2);
    chk("held_left_drop", drop_cnt - d0, 1);
    chk("held_left_q", q_level, 0);

    drive(K_DN);
    chk("down_queued", q_level, 1);
    tick_exp(2'd2);
    chk("down_dir", dir, 2);
    chk("down_q_empty", q_level, 0);

    // UP outranks LEFT and is a reversal of DOWN.
    d0 = drop_cnt;
    drive(K_UP | K_LT);
    chk("prio_up_drop", drop_cnt - d0, 1);
    chk("prio_up_q", q_level, 0);
    d0 = drop_cnt;
    drive(K_RT | K_LT);
    chk("prio_right_nodrop", drop_cnt - d0, 0);
    chk("prio_right_q", q_level, 1);
    tick_exp(2'd1);

    d0 = drop_cnt;
    drive(K_UP);
    drive(K_LT);
    drive(K_DN);
`ifdef SNAKE_DIR_QUEUE_EN
    chk("fifo_full_q", q_level, 2);
    chk("fifo_full_drop", drop_cnt - d0, 1);
    tick_exp(2'd0);
    tick_exp(2'd3);
`else
    chk("pend_q", q_level, 1);
    chk("pend_nodrop", drop_cnt - d0, 0);
    tick_exp(2'd2);
    drive(K_LT);
    tick_exp(2'd3);
`endif
    chk("burst_dir", dir, 3);
    chk("burst_q_empty", q_level, 0);

    // Push and pop together with one entry pending.
    drive(K_UP);
    chk("pp_q_before", q_level, 1);
    exp_q.push_back(2'd0);
    drive(K_RT | K_TK);
    chk("pp_step_seen", exp_q.size(), 0);
    chk("pp_dir", dir, 0);
    chk("pp_q_after", q_level, 1);
    tick_exp(2'd1);
    chk("pp_drain_q", q_level, 0);

    // Push on empty with tick: step uses old heading.
    exp_q.push_back(2'd1);
    drive(K_DN | K_TK);
    chk("pe_step_seen", exp_q.size(), 0);
    chk("pe_dir", dir, 1);
    chk("pe_q", q_level, 1);
    tick_exp(2'd2);

    s0 = step_cnt;
    drive(K_CO | K_TK);
    chk("coll_over", game_state, 2);
    chk("coll_nostep", step_cnt - s0, 0);
    d0 = drop_cnt;
    drive(K_TK);
    drive(K_LT);
    drive(K_TK);
    chk("over_nostep", step_cnt - s0, 0);
    chk("over_dir_frozen", dir, 2);
    chk("over_nodrop", drop_cnt - d0, 0);
    chk("over_q", q_level, 0);

    drive(K_CR | K_ST);
    chk("creset_idle", game_state, 0);
    chk("creset_dir", dir, 1);
    chk("creset_q", q_level, 0);
    drive(K_ST);
    chk("restart_playing", game_state, 1);
    tick_exp(2'd1);

    drive(K_DN);
    chk("flush_q_before", q_level, 1);
    drive(K_CR);
    chk("flush_idle", game_state, 0);
    chk("flush_q", q_level, 0);
    chk("flush_dir", dir, 1);
    s0 = step_cnt;
    drive(K_TK);
    chk("idle_nostep", step_cnt - s0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
